// File: rtl/mux_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux_arb_pkg                                                              |
// | Shared state encoding and width helper for the round-robin mux arbiter.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mux_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Ceiling log2 with a floor of 1 so a select port always has at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux_rr_pick                                                              |
// | Combinational round-robin pick: first set Req bit after Ptr, wrapping.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mux_rr_pick
  import mux_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = clog2(N)
) (
  input  logic [N-1:0]  Req,
  input  logic [SW-1:0] Ptr,
  output logic          Any,
  output logic [SW-1:0] Win
);

  // Rotated priority encode: offset i from Ptr maps back to index (Ptr+i) mod N.
  always_comb begin
    int idx;
    idx = 0;
    Any = 1'b0;
    Win = '0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(Ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!Any && Req[idx]) begin
        Any = 1'b1;
        Win = SW'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux_rr_arbiter                                                           |
// | Round-robin arbiter with registered N:1 data capture and valid/ready.    |
// | Optional feature macro: ARB_LOCK_EN (adds Lock port, sticky grant).      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = clog2(N)
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic [N-1:0]   Req,
  input  logic [N*W-1:0] Data_In,
  input  logic           Out_Ready,
  output logic [N-1:0]   Grant,
  output logic [SW-1:0]  Sel,
  output logic [W-1:0]   Out,
  output logic           Out_Valid
`ifdef ARB_LOCK_EN
  ,
  input  logic [N-1:0]   Lock
`endif
);

  state_t        r_state;
  logic [SW-1:0] r_ptr;

  logic          w_xfer;
  logic [SW-1:0] w_pick_ptr;
  logic          w_any;
  logic [SW-1:0] w_win;
  logic          w_hold;
  logic          w_load;
  logic [SW-1:0] w_load_idx;
  logic [W-1:0]  w_data;

  assign w_xfer = (r_state == ST_BUSY) && Out_Ready;

  // On a transfer the pointer moves to the current grantee in the same edge,
  // so the search must already start after Sel rather than after r_ptr.
  assign w_pick_ptr = w_xfer ? Sel : r_ptr;

  mux_rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .Req (Req),
    .Ptr (w_pick_ptr),
    .Any (w_any),
    .Win (w_win)
  );

`ifdef ARB_LOCK_EN
  assign w_hold = w_xfer && Lock[Sel] && Req[Sel];
`else
  assign w_hold = 1'b0;
`endif

  assign w_load     = w_hold || w_any;
  assign w_load_idx = w_hold ? Sel : w_win;
  assign w_data     = Data_In[w_load_idx*W +: W];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= SW'(N - 1);
      Grant     <= '0;
      Sel       <= '0;
      Out       <= '0;
      Out_Valid <= 1'b0;
    end else if (r_state == ST_IDLE || w_xfer) begin
      if (w_xfer && !w_hold) r_ptr <= Sel;
      if (w_load) begin
        r_state   <= ST_BUSY;
        Grant     <= N'(1) << w_load_idx;
        Sel       <= w_load_idx;
        Out       <= w_data;
        Out_Valid <= 1'b1;
      end else begin
        r_state   <= ST_IDLE;
        Grant     <= '0;
        Out_Valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mux_rr_arbiter                                                        |
// | Scoreboard bench for mux_rr_arbiter (lock scenario under ARB_LOCK_EN).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mux_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [W-1:0]  data;
  } exp_t;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] data_in;
  logic           out_ready;
  logic [N-1:0]   grant;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out;
  logic           out_valid;
`ifdef ARB_LOCK_EN
  logic [N-1:0]   lock;
`endif

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  mux_rr_arbiter #(.N(N), .W(W)) dut (
    .Clk       (clk),
    .Rst       (rst),
    .Req       (req),
    .Data_In   (data_in),
    .Out_Ready (out_ready),
    .Grant     (grant),
    .Sel       (sel),
    .Out       (out),
    .Out_Valid (out_valid)
`ifdef ARB_LOCK_EN
    ,
    .Lock      (lock)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pushes every word the arbiter should capture.
  bit m_busy;
  int m_ptr;
  int m_sel;
  always @(posedge clk or posedge rst) begin : model
    int   k_idx;
    bit   found;
    bit   locked;
    exp_t e;
    if (rst) begin
      m_busy = 1'b0;
      m_ptr  = N - 1;
      m_sel  = 0;
      exp_q.delete();
    end else if (!m_busy || out_ready) begin
      found  = 1'b0;
      locked = 1'b0;
      k_idx  = 0;
`ifdef ARB_LOCK_EN
      if (m_busy && lock[m_sel] && req[m_sel]) locked = 1'b1;
`endif
      if (m_busy && !locked) m_ptr = m_sel;
      if (locked) begin
        found = 1'b1;
        k_idx = m_sel;
      end
      for (int k = 1; k <= N; k++) begin
        if (!found && req[(m_ptr + k) % N]) begin
          found = 1'b1;
          k_idx = (m_ptr + k) % N;
        end
      end
      if (found) begin
        m_busy = 1'b1;
        m_sel  = k_idx;
        e.sel  = SW'(k_idx);
        e.data = data_in[k_idx*W +: W];
        exp_q.push_back(e);
      end else begin
        m_busy = 1'b0;
      end
    end
  end

  task automatic apply_reset();
    rst       = 1'b1;
    req       = '0;
    out_ready = 1'b0;
    data_in   = '0;
`ifdef ARB_LOCK_EN
    lock      = '0;
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req       = '0;
    out_ready = 1'b0;
    data_in   = '0;
`ifdef ARB_LOCK_EN
    lock      = '0;
`endif
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000 || sel !== 2'd0 || out !== 8'h00 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got grant=%b sel=%0d out=%h valid=%b, expected 0000/0/00/0",
               grant, sel, out, out_valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   exp_seq[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    req       = 4'b1111;
    out_ready = 1'b1;
    data_in   = $urandom;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || sel !== SW'(exp_seq[i]) || grant !== (4'b0001 << exp_seq[i])) begin
        failures++;
        $display("FAIL b2b_rotation[%0d]: got valid=%b sel=%0d grant=%b, expected 1/%0d", i,
                 out_valid, sel, grant, exp_seq[i]);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL b2b_scoreboard[%0d]: got empty queue, expected one word", i);
      end else begin
        e = exp_q.pop_front();
        if (out !== e.data) begin
          failures++;
          $display("FAIL b2b_data[%0d]: got %h expected %h", i, out, e.data);
        end
      end
      data_in = $urandom;
      if (i == 4) req = '0;
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || grant !== 4'b0000) begin
      failures++;
      $display("FAIL b2b_idle: got valid=%b grant=%b expected 0/0000", out_valid, grant);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    req       = 4'b0010;
    data_in   = 32'h1122_A533;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out !== 8'hA5 || grant !== 4'b0010 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got out=%h grant=%b valid=%b expected a5/0010/1", i,
                 out, grant, out_valid);
      end
      data_in = $urandom;
    end
    req       = '0;
    out_ready = 1'b1;
    checks++;
    if (exp_q.size() != 1) begin
      failures++;
      $display("FAIL stall_scoreboard: got %0d queued, expected 1", exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (e.data !== out || e.sel !== sel) begin
        failures++;
        $display("FAIL stall_word: got sel=%0d out=%h expected %0d/%h", sel, out, e.sel, e.data);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || grant !== 4'b0000 || out !== 8'hA5) begin
      failures++;
      $display("FAIL stall_release: got valid=%b grant=%b out=%h expected 0/0000/a5",
               out_valid, grant, out);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    req       = 4'b1000;
    data_in   = 32'h3C00_0000;
    out_ready = 1'b0;
    @(negedge clk);
    req     = 4'b0001;
    data_in = 32'h0000_0077;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (sel !== 2'd3 || out !== 8'h3C || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL wrap_hold[%0d]: got sel=%0d out=%h valid=%b expected 3/3c/1", i,
                 sel, out, out_valid);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    e = exp_q.pop_front();
    @(negedge clk);
    checks++;
    if (sel !== 2'd0 || out !== 8'h77 || grant !== 4'b0001 || e.sel !== 2'd3) begin
      failures++;
      $display("FAIL wrap_next: got sel=%0d out=%h grant=%b expected 0/77/0001", sel, out, grant);
    end
    req = '0;
    e   = exp_q.pop_front();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    req       = 4'b0001;
    out_ready = 1'b0;
    data_in   = 32'h0000_00E1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || sel !== 2'd0) begin
      failures++;
      $display("FAIL rstmid_pre: got valid=%b sel=%0d expected 1/0", out_valid, sel);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0000 || out_valid !== 1'b0 || sel !== 2'd0 || out !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_async: got grant=%b valid=%b sel=%0d out=%h expected 0000/0/0/00",
               grant, out_valid, sel, out);
    end
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (sel !== 2'd2 || grant !== 4'b0100 || exp_q.size() != 1) begin
      failures++;
      $display("FAIL rstmid_after: got sel=%0d grant=%b queued=%0d expected 2/0100/1",
               sel, grant, exp_q.size());
    end
    req       = '0;
    out_ready = 1'b1;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clk);
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    apply_reset();
    req       = 4'b0011;
    lock      = 4'b0001;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (sel !== 2'd0 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL lock_hold[%0d]: got sel=%0d valid=%b expected 0/1", i, sel, out_valid);
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    lock = '0;
    @(negedge clk);
    checks++;
    if (sel !== 2'd1) begin
      failures++;
      $display("FAIL lock_release: got sel=%0d expected 1", sel);
    end
    req = '0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clk);
  endtask
`endif

  task automatic test_random();
    exp_t         e;
    int           waits[N];
    bit           pend;
    logic [N-1:0] pend_req;
    bit           over;
    apply_reset();
    for (int i = 0; i < N; i++) waits[i] = 0;
    pend     = 1'b0;
    pend_req = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      checks++;
      if (grant !== (out_valid ? (4'b0001 << sel) : 4'b0000)) begin
        failures++;
        $display("FAIL rand_onehot[%0d]: got grant=%b sel=%0d valid=%b", cyc, grant, sel, out_valid);
      end
      checks++;
      if (exp_q.size() != (out_valid ? 1 : 0)) begin
        failures++;
        $display("FAIL rand_occupancy[%0d]: got %0d queued, expected %0d", cyc, exp_q.size(),
                 out_valid ? 1 : 0);
      end
      if (pend) begin
        over = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (sel == SW'(i) || !pend_req[i]) waits[i] = 0;
          else waits[i]++;
          if (waits[i] > N - 1) over = 1'b1;
        end
        checks++;
        if (over) begin
          failures++;
          $display("FAIL rand_fairness[%0d]: got a wait above %0d loads", cyc, N - 1);
        end
      end
      req       = N'($urandom_range(0, 15));
      data_in   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      pend      = (!out_valid || out_ready) && (req != '0);
      pend_req  = req;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_scoreboard[%0d]: got empty queue at transfer", cyc);
        end else begin
          e = exp_q.pop_front();
          if (sel !== e.sel || out !== e.data) begin
            failures++;
            $display("FAIL rand_word[%0d]: got sel=%0d out=%h expected %0d/%h", cyc, sel, out,
                     e.sel, e.data);
          end
        end
      end
    end
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_reset_mid();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
